register_file_sb: RTL and testbench
===================================

// Module: register_file_sb
// PURPOSE
//  Parametrised successor to the 4x16 two-read/one-write register file: N x W storage, two async read ports,
//  one sync write port with explicit write address, plus a per-register busy scoreboard for hazard detection.
//  Sits between decode (reserve/read) and writeback (write) in the TinyChip datapath.
// PARAMETERS
//  DATA_W    16  width of each register and of all data ports
//  NUM_REGS  4   number of registers (>=2; need not be a power of two)
//  ZERO_REG  0   1: register 0 reads as 0, ignores writes and reservations
//  (localparam ADDR_W = $clog2(NUM_REGS))
// PORTS
//  clk         in   1       single clock, all state updates on rising edge
//  reset       in   1       asynchronous, active-low; clears all registers and busy bits
//  reg1        in   ADDR_W  read address, port 1
//  reg2        in   ADDR_W  read address, port 2
//  data1       out  DATA_W  read data, port 1 (combinational)
//  data2       out  DATA_W  read data, port 2 (combinational)
//  busy1       out  1       busy bit of reg1 (combinational)
//  busy2       out  1       busy bit of reg2 (combinational)
//  write       in   1       write enable
//  write_reg   in   ADDR_W  write address
//  write_data  in   DATA_W  write data
//  reserve     in   1       mark rsv_reg busy (pending producer)
//  rsv_reg     in   ADDR_W  register to reserve
//  busy_cnt    out  ADDR_W+1  number of busy registers
// BEHAVIOUR
//  - reset low (any time, incl. mid-write): regs <= 0, busy <= 0 immediately; data1/2=0, busy1/2=0, busy_cnt=0.
//    Write/reserve in the same cycle as reset release edge are ignored.
//  - Read: data1 = regs[reg1], data2 = regs[reg2], zero latency; out-of-range address -> 0, busy 0.
//  - Write: posedge with write=1 -> regs[write_reg] <= write_data; busy[write_reg] <= 0. Visible on data1/2 the
//    cycle after (see REGFILE_BYPASS_EN). Out-of-range write_reg: no effect.
//  - Reserve: posedge with reserve=1 -> busy[rsv_reg] <= 1.
//  - Write and reserve to SAME register same cycle: data written, busy ends 1 (new producer wins).
//  - Write and reserve to different registers: both take effect.
//  - Reserve of an already-busy register: stays 1, busy_cnt unchanged.
//  - Write to a non-busy register: legal, data written, busy stays 0.
//  - ZERO_REG=1: writes/reserves to address 0 ignored; data/busy for address 0 always 0.
//  - busy_cnt registered alongside busy bits: always equals popcount(busy) after each edge; max NUM_REGS.
//  - Both read ports may address the same register; both return identical values.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: if write=1 and write_reg==regN (in range, not zero-reg), dataN = write_data and
//    busyN = 0 in that same cycle (unless reserve to same reg, then busyN = 1 still shows current state=old busy
//    cleared -> 0); register update still occurs at the edge.
//  REGFILE_BYPASS_EN undefined: dataN/busyN reflect stored state only; new value appears one cycle after write.
// TESTING (defaults DATA_W=16, NUM_REGS=4, ZERO_REG=0)
//  1 reset=0 then 1; reg1=0, reg2=3 -> data1=data2=16'h0000, busy1=busy2=0, busy_cnt=0.
//  2 write=1, write_reg=2, write_data=16'hABCD one cycle; reg1=2 -> data1=16'hABCD next cycle; with
//    REGFILE_BYPASS_EN data1=16'hABCD during the write cycle, without it 16'h0000 during the write cycle.
//  3 reserve rsv_reg=1 -> busy2=1 (reg2=1), busy_cnt=1; next cycle write reg 1 16'h1234 -> busy2=0,
//    data2=16'h1234, busy_cnt=0.
//  4 same cycle write reg 3 16'h5555 and reserve reg 3 -> data at reg 3 = 16'h5555, busy=1, busy_cnt=1.
//  5 ZERO_REG=1 build: write reg 0 16'hFFFF and reserve reg 0 -> data1 (reg1=0)=0, busy1=0, busy_cnt=0.
//  6 reserve regs 1..3 over 3 cycles (busy_cnt=3), assert reset low mid-cycle -> all busy 0, busy_cnt=0,
//    all data 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/register_file_sb.sv
// N x W register file: two async read ports, one sync write port, per-register busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data/busy-clear to the read ports.
module register_file_sb #(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 4,
    parameter  int ZERO_REG = 0,
    localparam int ADDR_W   = $clog2(NUM_REGS),
    localparam int CNT_W    = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] reg1,
    input  logic [ADDR_W-1:0] reg2,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] rsv_reg,
    output logic [CNT_W-1:0]  busy_cnt
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [NUM_REGS-1:0] wr_sel;
    logic [NUM_REGS-1:0] rsv_sel;
    logic [CNT_W-1:0]    cnt_nxt;

    // Per-register decode; out-of-range and hardwired-zero addresses never select anything.
    always_comb begin
        wr_sel  = '0;
        rsv_sel = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (!((ZERO_REG != 0) && (i == 0))) begin
                wr_sel[i]  = write   && (write_reg == ADDR_W'(i));
                rsv_sel[i] = reserve && (rsv_reg   == ADDR_W'(i));
            end
        end
    end

    // Reserve is applied after the write clear so a new producer wins on the same register.
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_sel[i])  busy_nxt[i] = 1'b0;
            if (rsv_sel[i]) busy_nxt[i] = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) regs[i] <= write_data;
            end
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        data1 = '0;
        data2 = '0;
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (!((ZERO_REG != 0) && (i == 0))) begin
                if (reg1 == ADDR_W'(i)) begin
                    data1 = regs[i];
                    busy1 = busy[i];
`ifdef REGFILE_BYPASS_EN
                    if (reset && wr_sel[i]) begin
                        data1 = write_data;
                        busy1 = 1'b0;
                    end
`endif
                end
                if (reg2 == ADDR_W'(i)) begin
                    data2 = regs[i];
                    busy2 = busy[i];
`ifdef REGFILE_BYPASS_EN
                    if (reset && wr_sel[i]) begin
                        data2 = write_data;
                        busy2 = 1'b0;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: table of single-cycle operations plus hand sequences
// for reset, same-cycle read during write, hardwired zero register and async mid-cycle reset.
module tb_register_file_sb;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] reg1, reg2, write_reg, rsv_reg;
    logic [DATA_W-1:0] write_data;
    logic              write, reserve;

    logic [DATA_W-1:0] data1, data2, z_data1, z_data2;
    logic              busy1, busy2, z_busy1, z_busy2;
    logic [ADDR_W:0]   busy_cnt, z_busy_cnt;

    int tests = 0;
    int fails = 0;

    register_file_sb #(.DATA_W(DATA_W), .NUM_REGS(4), .ZERO_REG(0)) u_dut (
        .clk(clk), .reset(reset), .reg1(reg1), .reg2(reg2),
        .data1(data1), .data2(data2), .busy1(busy1), .busy2(busy2),
        .write(write), .write_reg(write_reg), .write_data(write_data),
        .reserve(reserve), .rsv_reg(rsv_reg), .busy_cnt(busy_cnt)
    );

    register_file_sb #(.DATA_W(DATA_W), .NUM_REGS(4), .ZERO_REG(1)) u_zero (
        .clk(clk), .reset(reset), .reg1(reg1), .reg2(reg2),
        .data1(z_data1), .data2(z_data2), .busy1(z_busy1), .busy2(z_busy2),
        .write(write), .write_reg(write_reg), .write_data(write_data),
        .reserve(reserve), .rsv_reg(rsv_reg), .busy_cnt(z_busy_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] d1, input logic [15:0] d2,
                             input logic b1, input logic b2, input logic [2:0] cnt);
        check({name, ".data1"}, 32'(data1), 32'(d1));
        check({name, ".data2"}, 32'(data2), 32'(d2));
        check({name, ".busy1"}, 32'(busy1), 32'(b1));
        check({name, ".busy2"}, 32'(busy2), 32'(b2));
        check({name, ".cnt"},   32'(busy_cnt), 32'(cnt));
    endtask

    task automatic idle_inputs();
        write      = 1'b0;
        reserve    = 1'b0;
        write_reg  = '0;
        rsv_reg    = '0;
        write_data = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  wreg;
        logic [15:0] wdata;
        logic        rsv;
        logic [1:0]  rreg;
        logic [1:0]  r1;
        logic [1:0]  r2;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        b1;
        logic        b2;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        //                name        wr wreg wdata     rsv rreg r1 r2 d1        d2        b1 b2 cnt
        vecs[0]  = '{"wr2",          1, 2, 16'hABCD, 0, 0, 2, 3, 16'hABCD, 16'h0000, 0, 0, 0};
        vecs[1]  = '{"rsv1_same",    0, 0, 16'h0000, 1, 1, 1, 1, 16'h0000, 16'h0000, 1, 1, 1};
        vecs[2]  = '{"wr1_clear",    1, 1, 16'h1234, 0, 0, 0, 1, 16'h0000, 16'h1234, 0, 0, 0};
        vecs[3]  = '{"wr_rsv_same",  1, 3, 16'h5555, 1, 3, 3, 2, 16'h5555, 16'hABCD, 1, 0, 1};
        vecs[4]  = '{"rsv_again",    0, 0, 16'h0000, 1, 3, 3, 3, 16'h5555, 16'h5555, 1, 1, 1};
        vecs[5]  = '{"wr_rsv_diff",  1, 0, 16'h0F0F, 1, 2, 0, 2, 16'h0F0F, 16'hABCD, 0, 1, 2};
        vecs[6]  = '{"wr_nonbusy",   1, 0, 16'h7777, 0, 0, 0, 3, 16'h7777, 16'h5555, 0, 1, 2};
        vecs[7]  = '{"rsv0_wr2",     1, 2, 16'hBEEF, 1, 0, 2, 0, 16'hBEEF, 16'h7777, 0, 1, 2};
        vecs[8]  = '{"rsv1",         0, 0, 16'h0000, 1, 1, 1, 2, 16'h1234, 16'hBEEF, 1, 0, 3};
        vecs[9]  = '{"rsv2_full",    0, 0, 16'h0000, 1, 2, 2, 3, 16'hBEEF, 16'h5555, 1, 1, 4};
        vecs[10] = '{"wr3",          1, 3, 16'h0001, 0, 0, 3, 0, 16'h0001, 16'h7777, 0, 1, 3};
        vecs[11] = '{"noop",         0, 0, 16'h0000, 0, 0, 1, 0, 16'h1234, 16'h7777, 1, 1, 3};

        // Reset state, including operations presented while reset is held low.
        idle_inputs();
        reg1  = 2'd0;
        reg2  = 2'd3;
        reset = 1'b0;
        write = 1'b1; write_reg = 2'd3; write_data = 16'hFFFF;
        reserve = 1'b1; rsv_reg = 2'd3;
        #1;
        check_all("in_reset", 16'h0, 16'h0, 0, 0, 3'd0);
        @(posedge clk); @(posedge clk); #1;
        reg1 = 2'd3;
        #1;
        check_all("in_reset_ops", 16'h0, 16'h0, 0, 0, 3'd0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        reg1  = 2'd0;
        @(posedge clk); #2;
        check_all("post_reset", 16'h0, 16'h0, 0, 0, 3'd0);

        foreach (vecs[k]) begin
            @(negedge clk);
            write = vecs[k].wr; write_reg = vecs[k].wreg; write_data = vecs[k].wdata;
            reserve = vecs[k].rsv; rsv_reg = vecs[k].rreg;
            reg1 = vecs[k].r1; reg2 = vecs[k].r2;
            @(posedge clk); #1;
            idle_inputs();
            #1;
            check_all(vecs[k].name, vecs[k].d1, vecs[k].d2, vecs[k].b1, vecs[k].b2, vecs[k].cnt);
        end

        // Read of a register during the cycle it is written (reg 2 holds BEEF and is busy).
        @(negedge clk);
        write = 1'b1; write_reg = 2'd2; write_data = 16'h2222;
        reg1 = 2'd2; reg2 = 2'd1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cycle.data1", 32'(data1), 32'h2222);
        check("same_cycle.busy1", 32'(busy1), 32'd0);
`else
        check("same_cycle.data1", 32'(data1), 32'hBEEF);
        check("same_cycle.busy1", 32'(busy1), 32'd1);
`endif
        check("same_cycle.data2", 32'(data2), 32'h1234);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        check_all("after_write", 16'h2222, 16'h1234, 0, 1, 3'd2);

        // Hardwired zero register versus ordinary register 0.
        pulse_reset();
        write = 1'b1; write_reg = 2'd0; write_data = 16'hFFFF;
        reserve = 1'b1; rsv_reg = 2'd0;
        reg1 = 2'd0; reg2 = 2'd0;
        @(posedge clk); #1;
        idle_inputs();
        #1;
        check("zero.data1", 32'(z_data1), 32'h0);
        check("zero.data2", 32'(z_data2), 32'h0);
        check("zero.busy1", 32'(z_busy1), 32'd0);
        check("zero.cnt",   32'(z_busy_cnt), 32'd0);
        check("nonzero.data1", 32'(data1), 32'hFFFF);
        check("nonzero.busy1", 32'(busy1), 32'd1);
        check("nonzero.cnt",   32'(busy_cnt), 32'd1);

        // Reserve 1..3, then drop reset between clock edges.
        pulse_reset();
        write = 1'b1; write_reg = 2'd1; write_data = 16'hAAAA;
        reserve = 1'b1; rsv_reg = 2'd1;
        @(negedge clk);
        write = 1'b0; rsv_reg = 2'd2;
        @(negedge clk);
        rsv_reg = 2'd3;
        reg1 = 2'd1; reg2 = 2'd3;
        @(posedge clk); #1;
        idle_inputs();
        #1;
        check_all("rsv123", 16'hAAAA, 16'h0, 1, 1, 3'd3);
        #1;
        reset = 1'b0;
        #1;
        check_all("async_reset", 16'h0, 16'h0, 0, 0, 3'd0);
        reg1 = 2'd2; reg2 = 2'd0;
        #1;
        check_all("async_reset_b", 16'h0, 16'h0, 0, 0, 3'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
